// File: rtl/tlb_mp.sv
// tlb_mp: fully-associative MIPS-style joint TLB.
// Ports: clk/reset; NUM_LOOKUP registered lookup ports (lk_*); registered
// probe (tlbp_*) and read (tlbr_req/r_*); write port (we, wr_random, w_index,
// w_entry); Random/Wired counter (wired, wired_we, random); sequenced
// invalidate engine (flush_*).

package tlb_mp_pkg;
    localparam int unsigned TLB_ASID_W = 8;
    localparam int unsigned TLB_IDX_W  = 6;   // wide enough for 64 entries

    typedef struct packed {
        logic [18:0]           vpn2;
        logic [TLB_ASID_W-1:0] asid;
        logic                  g;
        logic [19:0]           pfn0;
        logic [2:0]            c0;
        logic                  d0;
        logic                  v0;
        logic [19:0]           pfn1;
        logic [2:0]            c1;
        logic                  d1;
        logic                  v1;
    } tlb_entry_t;

    typedef struct packed {
        logic                 found;
        logic [TLB_IDX_W-1:0] index;
        logic [19:0]          pfn;
        logic [2:0]           c;
        logic                 d;
        logic                 v;
    } tlb_search_t;
endpackage

module tlb_mp
    import tlb_mp_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned NUM_LOOKUP  = 3,
    parameter int unsigned ASID_W      = 8,
    localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ASID_W-1:0]                asid,
    input  logic [NUM_LOOKUP-1:0]            lk_valid,
    input  logic                             lk_stall,
    input  logic [NUM_LOOKUP-1:0][31:0]      lk_vaddr,
    output logic [NUM_LOOKUP-1:0]            lk_rvalid,
    output tlb_search_t [NUM_LOOKUP-1:0]     lk_result,
    output logic [NUM_LOOKUP-1:0]            lk_multi,
    input  logic                             tlbp_req,
    input  logic [31:0]                      tlbp_vaddr,
    output logic                             tlbp_done,
    output tlb_search_t                      tlbp_result,
    input  logic                             tlbr_req,
    input  logic [IDX_W-1:0]                 r_index,
    output logic                             r_done,
    output tlb_entry_t                       r_entry,
    input  logic                             we,
    input  logic                             wr_random,
    input  logic [IDX_W-1:0]                 w_index,
    input  tlb_entry_t                       w_entry,
    input  logic [IDX_W-1:0]                 wired,
    input  logic                             wired_we,
    output logic [IDX_W-1:0]                 random,
    input  logic                             flush_req,
    input  logic                             flush_by_asid,
    input  logic [ASID_W-1:0]                flush_asid,
    output logic                             flush_busy
);

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_ENTRIES - 1);

    typedef struct packed {
        logic        multi;
        tlb_search_t res;
    } hit_t;

    typedef enum logic {S_IDLE, S_SWEEP} fstate_t;

    tlb_entry_t  ram [NUM_ENTRIES];
    fstate_t     state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic              fl_by_asid, fl_by_asid_nxt;
    logic [ASID_W-1:0] fl_asid, fl_asid_nxt;

    // Associative search; scanning downwards leaves the lowest matching index.
    function automatic hit_t search(input logic [18:0] vpn2, input logic odd,
                                    input logic [ASID_W-1:0] a);
        hit_t h;
        logic seen;
        h    = '0;
        seen = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ram[i].vpn2 == vpn2 && (ram[i].g || ram[i].asid[ASID_W-1:0] == a)) begin
                h.multi     = h.multi | seen;
                seen        = 1'b1;
                h.res.found = 1'b1;
                h.res.index = TLB_IDX_W'(i);
                h.res.pfn   = odd ? ram[i].pfn1 : ram[i].pfn0;
                h.res.c     = odd ? ram[i].c1   : ram[i].c0;
                h.res.d     = odd ? ram[i].d1   : ram[i].d0;
                h.res.v     = odd ? ram[i].v1   : ram[i].v0;
            end
        end
        return h;
    endfunction

    hit_t [NUM_LOOKUP-1:0] lk_hit_c;
    hit_t                  tlbp_hit_c;
    logic [IDX_W-1:0]      wr_idx_c;
    logic                  sweep_sel_c;

    // Lookup and probe searches against the pre-edge contents.
    always_comb begin
        lk_hit_c = '0;
        for (int p = 0; p < int'(NUM_LOOKUP); p++) begin
            lk_hit_c[p] = search(lk_vaddr[p][31:13], lk_vaddr[p][12], asid);
        end
        tlbp_hit_c = search(tlbp_vaddr[31:13], tlbp_vaddr[12], asid);
    end

    assign wr_idx_c    = wr_random ? random : w_index;
    assign sweep_sel_c = (state == S_SWEEP) &&
                         (!fl_by_asid || (!ram[ptr].g && ram[ptr].asid[ASID_W-1:0] == fl_asid));

    // Flush sweep next-state.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        fl_by_asid_nxt = fl_by_asid;
        fl_asid_nxt    = fl_asid;
        case (state)
            S_IDLE: begin
                if (flush_req) begin
                    state_nxt      = S_SWEEP;
                    ptr_nxt        = '0;
                    fl_by_asid_nxt = flush_by_asid;
                    fl_asid_nxt    = flush_asid;
                end
            end
            S_SWEEP: begin
                ptr_nxt = ptr + IDX_W'(1);
                if (ptr == IDX_TOP) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Flush state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            fl_by_asid <= 1'b0;
            fl_asid    <= '0;
            flush_busy <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            fl_by_asid <= fl_by_asid_nxt;
            fl_asid    <= fl_asid_nxt;
            flush_busy <= (state_nxt == S_SWEEP);
        end
    end

    // Entry storage: a write to the entry under the sweep pointer wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (reset) begin
                ram[i] <= '0;
            end else if (we && wr_idx_c == IDX_W'(i)) begin
                ram[i] <= w_entry;
            end else if (sweep_sel_c && ptr == IDX_W'(i)) begin
                ram[i].v0 <= 1'b0;
                ram[i].v1 <= 1'b0;
            end
        end
    end

    // Random counter: wraps after reaching Wired (or 0); Wired writes reload it.
    always_ff @(posedge clk) begin
        if (reset || wired_we) begin
            random <= IDX_TOP;
        end else if (random == wired || random == '0) begin
            random <= IDX_TOP;
        end else begin
            random <= random - IDX_W'(1);
        end
    end

    // Registered lookup, probe and read results.
    always_ff @(posedge clk) begin
        if (reset) begin
            lk_rvalid   <= '0;
            lk_result   <= '0;
            lk_multi    <= '0;
            tlbp_done   <= 1'b0;
            tlbp_result <= '0;
            r_done      <= 1'b0;
            r_entry     <= '0;
        end else begin
            if (!lk_stall) begin
                lk_rvalid <= lk_valid;
                for (int p = 0; p < int'(NUM_LOOKUP); p++) begin
                    lk_result[p] <= lk_hit_c[p].res;
                    lk_multi[p]  <= lk_hit_c[p].multi;
                end
            end
            tlbp_done <= tlbp_req;
            if (tlbp_req) begin
                tlbp_result <= tlbp_hit_c.res;
            end
            r_done <= tlbr_req;
            if (tlbr_req) begin
                r_entry <= ram[r_index];
            end
        end
    end

endmodule

// File: tb/tb_tlb_mp.sv
// tb_tlb_mp: directed bench for tlb_mp with a reference model of the TLB
// contents, Random counter and invalidate sweep, compared every cycle.
module tb_tlb_mp;
    import tlb_mp_pkg::*;

    localparam int NE = 32;
    localparam int NL = 3;
    localparam int IW = 5;

    logic                    clk, reset;
    logic [7:0]              asid;
    logic [NL-1:0]           lk_valid;
    logic                    lk_stall;
    logic [NL-1:0][31:0]     lk_vaddr;
    logic [NL-1:0]           lk_rvalid;
    tlb_search_t [NL-1:0]    lk_result;
    logic [NL-1:0]           lk_multi;
    logic                    tlbp_req;
    logic [31:0]             tlbp_vaddr;
    logic                    tlbp_done;
    tlb_search_t             tlbp_result;
    logic                    tlbr_req;
    logic [IW-1:0]           r_index;
    logic                    r_done;
    tlb_entry_t              r_entry;
    logic                    we, wr_random;
    logic [IW-1:0]           w_index;
    tlb_entry_t              w_entry;
    logic [IW-1:0]           wired;
    logic                    wired_we;
    logic [IW-1:0]           random;
    logic                    flush_req, flush_by_asid;
    logic [7:0]              flush_asid;
    logic                    flush_busy;

    int total = 0;
    int bad   = 0;

    tlb_mp #(.NUM_ENTRIES(NE), .NUM_LOOKUP(NL), .ASID_W(8)) dut (
        .clk(clk), .reset(reset), .asid(asid),
        .lk_valid(lk_valid), .lk_stall(lk_stall), .lk_vaddr(lk_vaddr),
        .lk_rvalid(lk_rvalid), .lk_result(lk_result), .lk_multi(lk_multi),
        .tlbp_req(tlbp_req), .tlbp_vaddr(tlbp_vaddr), .tlbp_done(tlbp_done),
        .tlbp_result(tlbp_result), .tlbr_req(tlbr_req), .r_index(r_index),
        .r_done(r_done), .r_entry(r_entry), .we(we), .wr_random(wr_random),
        .w_index(w_index), .w_entry(w_entry), .wired(wired), .wired_we(wired_we),
        .random(random), .flush_req(flush_req), .flush_by_asid(flush_by_asid),
        .flush_asid(flush_asid), .flush_busy(flush_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] a,
                                      input logic g, input logic [19:0] p0,
                                      input logic [19:0] p1);
        tlb_entry_t e;
        e = '0;
        e.vpn2 = vpn2; e.asid = a; e.g = g;
        e.pfn0 = p0; e.pfn1 = p1;
        e.c0 = 3'd3; e.c1 = 3'd2; e.d0 = 1'b1;
        e.v0 = 1'b1; e.v1 = 1'b1;
        return e;
    endfunction

    // ---------------- reference model ----------------
    tlb_entry_t  m_ram [NE];
    int          m_random;
    int          m_flush_left;
    logic        m_by;
    logic [7:0]  m_fasid;
    bit          chk_en = 0;

    logic [NL-1:0] e_rvalid, e_multi;
    tlb_search_t   e_result [NL];
    logic          e_tlbp_done, e_r_done, e_busy;
    tlb_search_t   e_tlbp;
    tlb_entry_t    e_rent;

    // Lowest matching index wins; more than one hit flags multi.
    function automatic void model_search(input logic [31:0] va, input logic [7:0] a,
                                         output tlb_search_t r, output logic multi);
        int hits;
        hits = 0;
        r = '0;
        for (int i = 0; i < NE; i++) begin
            if (m_ram[i].vpn2 == va[31:13] && (m_ram[i].g || m_ram[i].asid == a)) begin
                if (hits == 0) begin
                    r.found = 1'b1;
                    r.index = 6'(i);
                    r.pfn   = va[12] ? m_ram[i].pfn1 : m_ram[i].pfn0;
                    r.c     = va[12] ? m_ram[i].c1   : m_ram[i].c0;
                    r.d     = va[12] ? m_ram[i].d1   : m_ram[i].d0;
                    r.v     = va[12] ? m_ram[i].v1   : m_ram[i].v0;
                end
                hits++;
            end
        end
        multi = (hits > 1);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            chk_en       = 1;
            for (int i = 0; i < NE; i++) m_ram[i] = '0;
            m_random     = NE - 1;
            m_flush_left = 0;
            e_rvalid = '0; e_multi = '0;
            for (int p = 0; p < NL; p++) e_result[p] = '0;
            e_tlbp_done = 0; e_r_done = 0; e_busy = 0;
            e_tlbp = '0; e_rent = '0;
        end else begin
            int tgt;
            if (!lk_stall) begin
                for (int p = 0; p < NL; p++) begin
                    tlb_search_t r;
                    logic m;
                    model_search(lk_vaddr[p], asid, r, m);
                    e_result[p] = r;
                    e_multi[p]  = m;
                    e_rvalid[p] = lk_valid[p];
                end
            end
            e_tlbp_done = tlbp_req;
            if (tlbp_req) begin
                logic m;
                model_search(tlbp_vaddr, asid, e_tlbp, m);
            end
            e_r_done = tlbr_req;
            if (tlbr_req) e_rent = m_ram[r_index];
            tgt = wr_random ? m_random : int'(w_index);
            if (m_flush_left > 0) begin
                int k;
                k = NE - m_flush_left;
                if (!m_by || (!m_ram[k].g && m_ram[k].asid == m_fasid)) begin
                    m_ram[k].v0 = 1'b0;
                    m_ram[k].v1 = 1'b0;
                end
                m_flush_left--;
            end else if (flush_req) begin
                m_flush_left = NE;
                m_by    = flush_by_asid;
                m_fasid = flush_asid;
            end
            e_busy = (m_flush_left > 0);
            if (we) m_ram[tgt] = w_entry;
            if (wired_we || m_random == int'(wired) || m_random == 0) m_random = NE - 1;
            else m_random = m_random - 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < NL; p++) begin
                chk($sformatf("lk_rvalid[%0d]", p), 128'(lk_rvalid[p]), 128'(e_rvalid[p]));
                chk($sformatf("lk_result[%0d]", p), 128'(lk_result[p]), 128'(e_result[p]));
                chk($sformatf("lk_multi[%0d]", p), 128'(lk_multi[p]), 128'(e_multi[p]));
            end
            chk("tlbp_done", 128'(tlbp_done), 128'(e_tlbp_done));
            if (e_tlbp_done) chk("tlbp_result", 128'(tlbp_result), 128'(e_tlbp));
            chk("r_done", 128'(r_done), 128'(e_r_done));
            if (e_r_done) chk("r_entry", 128'(r_entry), 128'(e_rent));
            chk("random", 128'(random), 128'(m_random));
            chk("flush_busy", 128'(flush_busy), 128'(e_busy));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    tlb_entry_t e5, ex, rd;
    int n;

    initial begin
        reset = 1; asid = 8'd3; lk_valid = '0; lk_stall = 0; lk_vaddr = '0;
        tlbp_req = 0; tlbp_vaddr = '0; tlbr_req = 0; r_index = '0;
        we = 0; wr_random = 0; w_index = '0; w_entry = '0;
        wired = '0; wired_we = 0; flush_req = 0; flush_by_asid = 0; flush_asid = '0;
        cyc(2);
        reset = 0;
        chk("reset random", 128'(random), 128'(31));
        chk("reset lk_rvalid", 128'(lk_rvalid), 128'(0));
        chk("reset flush_busy", 128'(flush_busy), 128'(0));

        // Lookup on an empty TLB misses everywhere.
        lk_valid = '1;
        for (int p = 0; p < NL; p++) lk_vaddr[p] = 32'h0040_0000;
        cyc(1);
        chk("empty found0", 128'(lk_result[0].found), 128'(0));
        chk("empty found2", 128'(lk_result[2].found), 128'(0));
        cyc(4);
        chk("random after 5", 128'(random), 128'(26));

        // TLBWI idx 5; a same-cycle lookup sees the old contents.
        e5 = mk(19'h00200, 8'd3, 1'b0, 20'h111, 20'h222);
        we = 1; w_index = 5'd5; w_entry = e5;
        lk_vaddr[1] = 32'h0040_1000;
        cyc(1);
        we = 0;
        chk("same-cycle write miss", 128'(lk_result[0].found), 128'(0));
        cyc(1);
        chk("hit found", 128'(lk_result[0].found), 128'(1));
        chk("hit index", 128'(lk_result[0].index), 128'(5));
        chk("hit pfn even", 128'(lk_result[0].pfn), 128'(20'h111));
        chk("hit pfn odd", 128'(lk_result[1].pfn), 128'(20'h222));
        asid = 8'd4;
        cyc(1);
        chk("asid mismatch", 128'(lk_result[0].found), 128'(0));
        asid = 8'd3;

        // Duplicate VPN2 in 7 and 2: lowest index, multi-hit flagged.
        we = 1; w_index = 5'd7; cyc(1);
        w_index = 5'd2; cyc(1);
        we = 0;
        tlbp_req = 1; tlbp_vaddr = 32'h0040_0000;
        cyc(1);
        tlbp_req = 0;
        chk("multi index", 128'(lk_result[0].index), 128'(2));
        chk("multi flag", 128'(lk_multi[0]), 128'(1));
        chk("tlbp_done pulse", 128'(tlbp_done), 128'(1));
        chk("tlbp index", 128'(tlbp_result.index), 128'(2));
        chk("tlbp found", 128'(tlbp_result.found), 128'(1));
        cyc(1);
        chk("tlbp_done drop", 128'(tlbp_done), 128'(0));

        // Wired=4, then TLBWR at random=10.
        wired = 5'd4; wired_we = 1;
        cyc(1);
        wired_we = 0;
        chk("random after wired_we", 128'(random), 128'(31));
        cyc(21);
        chk("random at 10", 128'(random), 128'(10));
        ex = mk(19'h0abcd, 8'd9, 1'b1, 20'h0beef, 20'h0cafe);
        we = 1; wr_random = 1; w_entry = ex;
        cyc(1);
        we = 0; wr_random = 0;
        tlbr_req = 1; r_index = 5'd10;
        cyc(1);
        tlbr_req = 0;
        chk("tlbwr r_done", 128'(r_done), 128'(1));
        chk("tlbwr r_entry", 128'(r_entry), 128'(ex));
        cyc(4);
        chk("random at wired", 128'(random), 128'(4));
        cyc(1);
        chk("random wrap", 128'(random), 128'(31));

        // Fill all entries, then flush by ASID 3.
        for (int i = 0; i < NE; i++) begin
            we = 1; w_index = IW'(i);
            w_entry = mk(19'h01000 + 19'(i), (i % 2 == 0) ? 8'd3 : 8'd5, (i == 6),
                         20'(i), 20'h100 + 20'(i));
            cyc(1);
        end
        we = 0;
        lk_vaddr[0] = 32'(19'h01000) << 13;
        lk_vaddr[1] = 32'(19'h01001) << 13;
        lk_vaddr[2] = 32'(19'h01006) << 13;
        flush_by_asid = 1; flush_asid = 8'd3; flush_req = 1;
        cyc(1);
        flush_req = 0;
        n = 0;
        while (flush_busy === 1'b1 && n < 100) begin n++; cyc(1); end
        chk("asid sweep length", 128'(n), 128'(32));
        for (int i = 0; i < NE; i++) begin
            tlbr_req = 1; r_index = IW'(i);
            cyc(1);
            rd = r_entry;
            chk($sformatf("asid flush v0[%0d]", i), 128'(rd.v0),
                128'((i % 2 == 0 && i != 6) ? 0 : 1));
        end
        tlbr_req = 0;

        // Full flush invalidates everything.
        flush_by_asid = 0; flush_req = 1;
        cyc(1);
        flush_req = 0;
        n = 0;
        while (flush_busy === 1'b1 && n < 100) begin n++; cyc(1); end
        chk("full sweep length", 128'(n), 128'(32));
        for (int i = 1; i < NE; i += 10) begin
            tlbr_req = 1; r_index = IW'(i);
            cyc(1);
            rd = r_entry;
            chk($sformatf("full flush v1[%0d]", i), 128'(rd.v1), 128'(0));
        end
        tlbr_req = 0;

        // Stall freezes lookup outputs while vaddr moves.
        we = 1; w_index = 5'd5; w_entry = e5;
        cyc(1);
        we = 0;
        lk_vaddr[0] = 32'h0040_0000;
        cyc(1);
        chk("pre-stall pfn", 128'(lk_result[0].pfn), 128'(20'h111));
        lk_stall = 1; lk_valid = '0;
        for (int k = 0; k < 3; k++) begin
            lk_vaddr[0] = 32'h0040_1000 + 32'(k) * 32'h2000;
            cyc(1);
            chk("stall pfn hold", 128'(lk_result[0].pfn), 128'(20'h111));
            chk("stall rvalid hold", 128'(lk_rvalid[0]), 128'(1));
        end
        lk_stall = 0;

        // Reset during a sweep at ptr 10.
        flush_req = 1;
        cyc(1);
        flush_req = 0;
        cyc(10);
        reset = 1;
        cyc(1);
        reset = 0;
        chk("reset mid-sweep busy", 128'(flush_busy), 128'(0));
        tlbr_req = 1; r_index = 5'd5;
        cyc(1);
        tlbr_req = 0;
        chk("reset cleared entry", 128'(r_entry), 128'(0));
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
